// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the branch sequencer: IR field layout, opcodes,
// FSM state encoding and the per-state strobe decode.
package branch_sequencer_pkg;

    localparam int unsigned IR_W  = 32;
    localparam int unsigned OP_HI = 31;
    localparam int unsigned OP_LO = 27;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned C2_HI = 22;
    localparam int unsigned C2_LO = 19;
    localparam int unsigned C2_W  = 4;
    localparam int unsigned C_HI  = 18;
    localparam int unsigned C_W   = 19;

    localparam logic [OP_W-1:0] OP_LOAD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_STORE  = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD    = 5'b00011;
    localparam logic [OP_W-1:0] OP_BRANCH = 5'b10010;
    localparam logic [OP_W-1:0] OP_JUMP   = 5'b10011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T3   = 3'd1,
        ST_T4   = 3'd2,
        ST_T5   = 3'd3,
        ST_T6   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // pc_en marks T6; the final pc_in is pc_en qualified by the live CON value.
    typedef struct packed {
        logic gra;
        logic r_out;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic alu_add;
        logic z_in;
        logic zlo_out;
        logic pc_en;
    } strobe_t;

    function automatic strobe_t strobes_of(input state_t s);
        strobe_t st;
        st = '0;
        case (s)
            ST_T3: begin
                st.gra    = 1'b1;
                st.r_out  = 1'b1;
                st.con_in = 1'b1;
            end
            ST_T4: begin
                st.pc_out = 1'b1;
                st.y_in   = 1'b1;
            end
            ST_T5: begin
                st.c_out   = 1'b1;
                st.alu_add = 1'b1;
                st.z_in    = 1'b1;
            end
            ST_T6: begin
                st.zlo_out = 1'b1;
                st.pc_en   = 1'b1;
            end
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Handshake and datapath-control bundle between the main control unit
// (master) and the branch sequencer (slave).
interface branch_sequencer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              start;
    logic [31:0]       ir;
    logic              con;
    logic              busy;
    logic              done;
    logic              illegal;
    logic [3:0]        c2;
    logic [DATA_W-1:0] c_sext;
    logic              gra;
    logic              r_out;
    logic              con_in;
    logic              pc_out;
    logic              y_in;
    logic              c_out;
    logic              alu_add;
    logic              z_in;
    logic              zlo_out;
    logic              pc_in;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  nottaken_cnt;

    modport master (
        output start, ir, con,
        input  busy, done, illegal, c2, c_sext,
        input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in,
        input  taken_cnt, nottaken_cnt
    );

    modport slave (
        input  start, ir, con,
        output busy, done, illegal, c2, c_sext,
        output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in,
        output taken_cnt, nottaken_cnt
    );
endinterface

// File: rtl/branch_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Steps a conditional branch through phases T3..T6, strobing the CON latch
// and loading PC only when the latched condition is true.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int unsigned     DATA_W        = 32,
    parameter logic [OP_W-1:0] OPCODE_BR     = OP_BRANCH,
    parameter int unsigned     CNT_W         = 16,
    parameter bit              SKIP_ON_FALSE = 1'b0
) (
    input logic               clk,
    input logic               reset,
    branch_sequencer_if.slave bus
);

    state_t            state;
    state_t            state_n;
    logic              accept;
    logic              reject;
    logic              inc_taken;
    logic              inc_nottaken;
    strobe_t           strb_q;
    logic              busy_q;
    logic              done_q;
    logic              illegal_q;
    logic [C2_W-1:0]   c2_q;
    logic [DATA_W-1:0] c_sext_q;
    logic [OP_W-1:0]   opcode;

    assign opcode = bus.ir[OP_HI:OP_LO];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, handoff decode and counter increments
    always_comb begin
        state_n      = state;
        accept       = 1'b0;
        reject       = 1'b0;
        inc_taken    = 1'b0;
        inc_nottaken = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (opcode == OPCODE_BR) begin
                        accept  = 1'b1;
                        state_n = ST_T3;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_T3: state_n = ST_T4;
            ST_T4: begin
                if (SKIP_ON_FALSE && !bus.con) begin
                    state_n      = ST_DONE;
                    inc_nottaken = 1'b1;
                end else begin
                    state_n = ST_T5;
                end
            end
            ST_T5: state_n = ST_T6;
            ST_T6: begin
                state_n      = ST_DONE;
                inc_taken    = bus.con;
                inc_nottaken = !bus.con;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each is a clean Moore output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strb_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            c2_q      <= '0;
            c_sext_q  <= '0;
        end else begin
            strb_q    <= strobes_of(state_n);
            busy_q    <= (state_n != ST_IDLE);
            done_q    <= (state_n == ST_DONE);
            illegal_q <= reject;
            if (accept) begin
                c2_q     <= bus.ir[C2_HI:C2_LO];
                c_sext_q <= {{(DATA_W-C_W){bus.ir[C_HI]}}, bus.ir[C_HI:0]};
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_taken),
        .q     (bus.taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_nottaken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_nottaken),
        .q     (bus.nottaken_cnt)
    );

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.c2      = c2_q;
    assign bus.c_sext  = c_sext_q;
    assign bus.gra     = strb_q.gra;
    assign bus.r_out   = strb_q.r_out;
    assign bus.con_in  = strb_q.con_in;
    assign bus.pc_out  = strb_q.pc_out;
    assign bus.y_in    = strb_q.y_in;
    assign bus.c_out   = strb_q.c_out;
    assign bus.alu_add = strb_q.alu_add;
    assign bus.z_in    = strb_q.z_in;
    assign bus.zlo_out = strb_q.zlo_out;
    // PC loads in T6 only while the latched condition holds.
    assign bus.pc_in   = strb_q.pc_en & bus.con;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized self-checking bench: two sequencers (plain, and skip-on-false
// with 2-bit counters) checked cycle by cycle against a phase-list model.
module tb_branch_sequencer;

    logic clk;
    logic reset;

    branch_sequencer_if #(.DATA_W(32), .CNT_W(16)) ifa ();
    branch_sequencer_if #(.DATA_W(32), .CNT_W(2))  ifb ();

    branch_sequencer #(.DATA_W(32), .OPCODE_BR(5'b10010), .CNT_W(16), .SKIP_ON_FALSE(1'b0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    branch_sequencer #(.DATA_W(32), .OPCODE_BR(5'b10010), .CNT_W(2), .SKIP_ON_FALSE(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, per DUT (0 = plain, 1 = skip / 2-bit counters)
    int          taken_m[2];
    int          nottaken_m[2];
    int          cnt_max[2];
    logic [31:0] csext_m[2];
    logic [3:0]  c2_m[2];

    // Order: gra r_out con_in pc_out y_in c_out alu_add z_in zlo_out pc_in
    function automatic logic [9:0] obs_strb(input bit sel);
        if (sel) return {ifb.gra, ifb.r_out, ifb.con_in, ifb.pc_out, ifb.y_in,
                         ifb.c_out, ifb.alu_add, ifb.z_in, ifb.zlo_out, ifb.pc_in};
        return {ifa.gra, ifa.r_out, ifa.con_in, ifa.pc_out, ifa.y_in,
                ifa.c_out, ifa.alu_add, ifa.z_in, ifa.zlo_out, ifa.pc_in};
    endfunction

    function automatic logic [2:0] obs_flags(input bit sel);
        if (sel) return {ifb.busy, ifb.done, ifb.illegal};
        return {ifa.busy, ifa.done, ifa.illegal};
    endfunction

    function automatic logic [31:0] obs_csext(input bit sel);
        return sel ? ifb.c_sext : ifa.c_sext;
    endfunction

    function automatic logic [3:0] obs_c2(input bit sel);
        return sel ? ifb.c2 : ifa.c2;
    endfunction

    function automatic logic [15:0] obs_taken(input bit sel);
        return sel ? 16'(ifb.taken_cnt) : ifa.taken_cnt;
    endfunction

    function automatic logic [15:0] obs_nottaken(input bit sel);
        return sel ? 16'(ifb.nottaken_cnt) : ifa.nottaken_cnt;
    endfunction

    // Phase index: 0=T3 1=T4 2=T5 3=T6 4=DONE
    function automatic logic [9:0] exp_strobes(input int ph, input bit con_v);
        case (ph)
            0:       return 10'b1110000000;
            1:       return 10'b0001100000;
            2:       return 10'b0000011100;
            3:       return {9'b000000001, con_v};
            default: return 10'b0000000000;
        endcase
    endfunction

    function automatic logic [31:0] sext19(input logic [31:0] w);
        int v;
        v = int'(w[18:0]);
        if (w[18]) v = v - (1 << 19);
        return 32'(v);
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [31:0] ir_v);
        if (sel) begin ifb.start = st; ifb.ir = ir_v; end
        else     begin ifa.start = st; ifa.ir = ir_v; end
    endtask

    task automatic drive_con(input bit sel, input logic c);
        if (sel) ifb.con = c;
        else     ifa.con = c;
    endtask

    function automatic logic [31:0] rand_branch_ir();
        logic [31:0] w;
        w = $urandom;
        w[31:27] = 5'b10010;
        return w;
    endfunction

    // One handoff on the chosen DUT, checked every cycle until it is idle again.
    task automatic do_branch(input bit sel, input logic [31:0] ir_v, input bit con_v,
                             input bit extra_start);
        logic [4:0]  op;
        bit          legal;
        bit          skip;
        int          ncyc;
        int          ph;
        logic [31:0] junk;
        op    = ir_v[31:27];
        legal = (op == 5'b10010);
        skip  = sel && !con_v;
        ncyc  = skip ? 3 : 5;

        @(negedge clk);
        drive(sel, 1'b1, ir_v);
        drive_con(sel, 1'($urandom_range(0, 1)));
        @(posedge clk);
        #1;
        junk = $urandom;
        drive(sel, 1'b0, junk);

        if (!legal) begin
            @(negedge clk);
            vectors++;
            if (obs_flags(sel) !== 3'b001) begin
                miscompares++;
                $display("FAIL illegal_pulse dut=%0d flags(busy,done,illegal) got=%b exp=001", sel, obs_flags(sel));
            end
            vectors++;
            if (obs_strb(sel) !== 10'b0) begin
                miscompares++;
                $display("FAIL illegal_strobes dut=%0d got=%b exp=0", sel, obs_strb(sel));
            end
            vectors++;
            if (obs_csext(sel) !== csext_m[sel]) begin
                miscompares++;
                $display("FAIL illegal_csext_kept dut=%0d got=%h exp=%h", sel, obs_csext(sel), csext_m[sel]);
            end
            @(negedge clk);
            vectors++;
            if (obs_flags(sel) !== 3'b000) begin
                miscompares++;
                $display("FAIL illegal_one_cycle dut=%0d flags got=%b exp=000", sel, obs_flags(sel));
            end
            return;
        end

        csext_m[sel] = sext19(ir_v);
        c2_m[sel]    = ir_v[22:19];

        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            ph = (skip && k == 2) ? 4 : k;
            if (ph == 4) begin
                if (con_v) taken_m[sel]    = (taken_m[sel]    < cnt_max[sel]) ? taken_m[sel] + 1    : cnt_max[sel];
                else       nottaken_m[sel] = (nottaken_m[sel] < cnt_max[sel]) ? nottaken_m[sel] + 1 : cnt_max[sel];
            end
            vectors++;
            if (obs_strb(sel) !== exp_strobes(ph, con_v)) begin
                miscompares++;
                $display("FAIL strobes dut=%0d phase=%0d got=%b exp=%b", sel, ph, obs_strb(sel), exp_strobes(ph, con_v));
            end
            vectors++;
            if (obs_flags(sel) !== {1'b1, ph == 4, 1'b0}) begin
                miscompares++;
                $display("FAIL flags dut=%0d phase=%0d got=%b exp=%b", sel, ph, obs_flags(sel), {1'b1, ph == 4, 1'b0});
            end
            vectors++;
            if (obs_csext(sel) !== csext_m[sel] || obs_c2(sel) !== c2_m[sel]) begin
                miscompares++;
                $display("FAIL fields dut=%0d phase=%0d c_sext got=%h exp=%h c2 got=%h exp=%h",
                         sel, ph, obs_csext(sel), csext_m[sel], obs_c2(sel), c2_m[sel]);
            end
            vectors++;
            if (obs_taken(sel) !== 16'(taken_m[sel]) || obs_nottaken(sel) !== 16'(nottaken_m[sel])) begin
                miscompares++;
                $display("FAIL counters dut=%0d phase=%0d taken got=%0d exp=%0d nottaken got=%0d exp=%0d",
                         sel, ph, obs_taken(sel), taken_m[sel], obs_nottaken(sel), nottaken_m[sel]);
            end
            if (k == 0) drive_con(sel, con_v);
            if (extra_start && k == ncyc - 2) drive(sel, 1'b1, rand_branch_ir());
        end

        @(negedge clk);
        vectors++;
        if (obs_flags(sel) !== 3'b000 || obs_strb(sel) !== 10'b0) begin
            miscompares++;
            $display("FAIL back_to_idle dut=%0d flags got=%b strobes got=%b exp=0", sel, obs_flags(sel), obs_strb(sel));
        end
        drive(sel, 1'b0, $urandom);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            taken_m[i]    = 0;
            nottaken_m[i] = 0;
            csext_m[i]    = '0;
            c2_m[i]       = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (obs_strb(1'(s)) !== 10'b0 || obs_flags(1'(s)) !== 3'b0 || obs_csext(1'(s)) !== 32'b0 ||
                obs_c2(1'(s)) !== 4'b0 || obs_taken(1'(s)) !== 16'b0 || obs_nottaken(1'(s)) !== 16'b0) begin
                miscompares++;
                $display("FAIL %s dut=%0d strobes=%b flags=%b c_sext=%h c2=%h taken=%0d nottaken=%0d exp all 0",
                         tag, s, obs_strb(1'(s)), obs_flags(1'(s)), obs_csext(1'(s)), obs_c2(1'(s)),
                         obs_taken(1'(s)), obs_nottaken(1'(s)));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        drive_con(1'b0, 1'b0);
        drive_con(1'b1, 1'b0);
        clear_model();
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset_release");
    endtask

    task automatic test_taken();
        logic [31:0] w;
        w = {5'b10010, 4'h0, 4'h1, 19'h00010};
        do_branch(1'b0, w, 1'b1, 1'b0);
        vectors++;
        if (ifa.c_sext !== 32'h10 || ifa.taken_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL taken_result c_sext got=%h exp=00000010 taken got=%0d exp=1", ifa.c_sext, ifa.taken_cnt);
        end
    endtask

    task automatic test_not_taken();
        logic [31:0] w;
        w = {5'b10010, 4'h0, 4'h6, 19'h7FFFF};
        do_branch(1'b0, w, 1'b0, 1'b0);
        vectors++;
        if (ifa.c_sext !== 32'hFFFFFFFF || ifa.nottaken_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL not_taken_result c_sext got=%h exp=ffffffff nottaken got=%0d exp=1", ifa.c_sext, ifa.nottaken_cnt);
        end
    endtask

    task automatic test_skip();
        do_branch(1'b1, rand_branch_ir(), 1'b0, 1'b0);
        do_branch(1'b1, rand_branch_ir(), 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        w = $urandom;
        w[31:27] = 5'b00011;
        do_branch(1'b0, w, 1'b1, 1'b0);
        do_branch(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_branch(1'b0, rand_branch_ir(), 1'b1, 1'b1);
        do_branch(1'b1, rand_branch_ir(), 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b0, 1'b1, rand_branch_ir());
        drive_con(1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, $urandom);
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_strb(1'b0) !== 10'b0000011100) begin
            miscompares++;
            $display("FAIL pre_reset_t5 got=%b exp=0000011100", obs_strb(1'b0));
        end
        reset = 1'b0;
        clear_model();
        #1;
        check_all_zero("async_reset_mid");
        @(negedge clk);
        check_all_zero("reset_held");
        reset = 1'b1;
        do_branch(1'b0, rand_branch_ir(), 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        int exp_tab[5];
        exp_tab = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            do_branch(1'b1, rand_branch_ir(), 1'b1, 1'b0);
            vectors++;
            if (ifb.taken_cnt !== 2'(exp_tab[i])) begin
                miscompares++;
                $display("FAIL saturate step=%0d taken got=%0d exp=%0d", i, ifb.taken_cnt, exp_tab[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[31:27] = 5'b10010;
            do_branch(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        cnt_max[0] = 65535;
        cnt_max[1] = 3;
        test_reset();
        test_taken();
        test_not_taken();
        test_skip();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
